// File: rtl/vga_frame_painter_pkg.sv
// Shared geometry, colour reset value, FSM states and the clipped span test
// for the VGA frame painter.
package vga_frame_painter_pkg;

    localparam int unsigned FB_W      = 160;
    localparam int unsigned FB_H      = 120;
    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned X_W       = 8;
    localparam int unsigned Y_W       = 7;

    localparam logic [15:0] COLOUR_RST = 16'hFF00;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSweep  = 2'd1,
        StUpdate = 2'd2
    } state_t;

    // One bit wider than any coordinate, so start+len never wraps.
    function automatic logic in_span(
        input logic [8:0] pos,
        input logic [8:0] start,
        input logic [8:0] len
    );
        logic [8:0] w_end;
        w_end = start + len;
        return (pos >= start) && (pos < w_end);
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop synchroniser for vertical sync plus a one-cycle falling-edge pulse.
// All flops preset to 1 so that reset release never creates a false edge.
module vs_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vs,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_vs;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/vga_frame_painter.sv
// Repaints the one-bit frame buffer once per frame (filled rectangle on a
// cleared background) and steps the foreground colour every few frames.
module vga_frame_painter
    import vga_frame_painter_pkg::*;
#(
    parameter int unsigned FB_W          = vga_frame_painter_pkg::FB_W,
    parameter int unsigned FB_H          = vga_frame_painter_pkg::FB_H,
    parameter int unsigned COLOUR_PERIOD = 60,
    parameter logic [7:0]  COLOUR_STEP   = 8'h25
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 VGA_VS,
    input  logic [X_W-1:0]       RECT_X,
    input  logic [Y_W-1:0]       RECT_Y,
    input  logic [X_W-1:0]       RECT_W,
    input  logic [Y_W-1:0]       RECT_H,
    input  logic                 COLOUR_EN,
    output logic                 FB_WE,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic                 FB_DATA,
    output logic [15:0]          CONFIG_COLOURS,
    output logic                 BUSY,
    output logic [15:0]          FRAME_COUNT
);

    localparam int unsigned      COL_W    = (COLOUR_PERIOD > 1) ? $clog2(COLOUR_PERIOD) : 1;
    localparam logic [X_W-1:0]   X_LAST   = X_W'(FB_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(FB_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLOUR_PERIOD - 1);

    logic w_vs_fall;

    state_t r_state, w_state_d;

    logic [X_W-1:0]   r_x, w_x_d;
    logic [Y_W-1:0]   r_y, w_y_d;
    logic [X_W-1:0]   r_rect_x, w_rect_x_d;
    logic [Y_W-1:0]   r_rect_y, w_rect_y_d;
    logic [X_W-1:0]   r_rect_w, w_rect_w_d;
    logic [Y_W-1:0]   r_rect_h, w_rect_h_d;
    logic [COL_W-1:0] r_col_cnt, w_col_cnt_d;
    logic [15:0]      r_colours, w_colours_d;
    logic [15:0]      r_frame_cnt, w_frame_cnt_d;

    logic                 r_we, w_we_d;
    logic [FB_ADDR_W-1:0] r_addr, w_addr_d;
    logic                 r_data, w_data_d;
    logic                 r_busy, w_busy_d;

    vs_edge_sync u_vs_edge_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_vs    (VGA_VS),
        .o_fall  (w_vs_fall)
    );

    // Sweep FSM: r_x/r_y always hold the pixel being written while in StSweep.
    always_comb begin
        w_state_d  = r_state;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_rect_x_d = r_rect_x;
        w_rect_y_d = r_rect_y;
        w_rect_w_d = r_rect_w;
        w_rect_h_d = r_rect_h;

        unique case (r_state)
            StIdle: begin
                if (w_vs_fall) begin
                    w_rect_x_d = RECT_X;
                    w_rect_y_d = RECT_Y;
                    w_rect_w_d = RECT_W;
                    w_rect_h_d = RECT_H;
                    w_x_d      = '0;
                    w_y_d      = '0;
                    w_state_d  = StSweep;
                end
            end
            StSweep: begin
                if (r_x == X_LAST) begin
                    w_x_d = '0;
                    if (r_y == Y_LAST) begin
                        w_state_d = StUpdate;
                    end else begin
                        w_y_d = r_y + 1'b1;
                    end
                end else begin
                    w_x_d = r_x + 1'b1;
                end
            end
            StUpdate: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs are computed from next state so the write lands in the same
    // cycle the FSM enters the pixel, keeping FB_WE/FB_ADDR/FB_DATA aligned.
    always_comb begin
        w_we_d   = (w_state_d == StSweep);
        w_busy_d = (w_state_d != StIdle);
        w_addr_d = '0;
        w_data_d = 1'b0;
        if (w_we_d) begin
            w_addr_d = {w_y_d, w_x_d};
            w_data_d = in_span({1'b0, w_x_d}, {1'b0, w_rect_x_d}, {1'b0, w_rect_w_d}) &&
                       in_span({2'b0, w_y_d}, {2'b0, w_rect_y_d}, {2'b0, w_rect_h_d});
        end
    end

    always_comb begin
        w_frame_cnt_d = r_frame_cnt;
        w_col_cnt_d   = r_col_cnt;
        w_colours_d   = r_colours;
        if (w_state_d == StUpdate) begin
            w_frame_cnt_d = r_frame_cnt + 16'd1;
            if (COLOUR_EN) begin
                if (r_col_cnt == COL_LAST) begin
                    w_col_cnt_d = '0;
                    w_colours_d = {r_colours[15:8] + COLOUR_STEP, r_colours[7:0]};
                end else begin
                    w_col_cnt_d = r_col_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= StIdle;
            r_x         <= '0;
            r_y         <= '0;
            r_rect_x    <= '0;
            r_rect_y    <= '0;
            r_rect_w    <= '0;
            r_rect_h    <= '0;
            r_col_cnt   <= '0;
            r_colours   <= COLOUR_RST;
            r_frame_cnt <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_x         <= w_x_d;
            r_y         <= w_y_d;
            r_rect_x    <= w_rect_x_d;
            r_rect_y    <= w_rect_y_d;
            r_rect_w    <= w_rect_w_d;
            r_rect_h    <= w_rect_h_d;
            r_col_cnt   <= w_col_cnt_d;
            r_colours   <= w_colours_d;
            r_frame_cnt <= w_frame_cnt_d;
            r_we        <= w_we_d;
            r_addr      <= w_addr_d;
            r_data      <= w_data_d;
            r_busy      <= w_busy_d;
        end
    end

    assign FB_WE          = r_we;
    assign FB_ADDR        = r_addr;
    assign FB_DATA        = r_data;
    assign CONFIG_COLOURS = r_colours;
    assign BUSY           = r_busy;
    assign FRAME_COUNT    = r_frame_cnt;

endmodule

// File: tb/tb_vga_frame_painter.sv
// Directed bench for vga_frame_painter: table of whole-frame repaints plus
// hand-written reset sequences.
module tb_vga_frame_painter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        VGA_VS;
    logic [7:0]  RECT_X;
    logic [6:0]  RECT_Y;
    logic [7:0]  RECT_W;
    logic [6:0]  RECT_H;
    logic        COLOUR_EN;
    logic        FB_WE;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic [15:0] CONFIG_COLOURS;
    logic        BUSY;
    logic [15:0] FRAME_COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int WINDOW = 19210;

    typedef struct {
        logic [7:0]  rx;
        logic [6:0]  ry;
        logic [7:0]  rw;
        logic [6:0]  rh;
        logic        col_en;
        int          overlap_at;   // 0 = no second VS edge
        int          exp_ones;
        int          exp_first;    // -1 = no foreground pixel
        int          exp_last;
        int          exp_colours;
        int          exp_frames;
    } vec_t;

    vec_t vecs[3];

    vga_frame_painter #(
        .COLOUR_PERIOD (2)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .VGA_VS         (VGA_VS),
        .RECT_X         (RECT_X),
        .RECT_Y         (RECT_Y),
        .RECT_W         (RECT_W),
        .RECT_H         (RECT_H),
        .COLOUR_EN      (COLOUR_EN),
        .FB_WE          (FB_WE),
        .FB_ADDR        (FB_ADDR),
        .FB_DATA        (FB_DATA),
        .CONFIG_COLOURS (CONFIG_COLOURS),
        .BUSY           (BUSY),
        .FRAME_COUNT    (FRAME_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int writes, ones, first_one, last_one, first_cyc, last_cyc, first_addr;
        int seq_err, busy_cyc, ex, ey;
        logic [14:0] exp_addr;
        writes = 0; ones = 0; first_one = -1; last_one = -1;
        first_cyc = -1; last_cyc = -1; first_addr = -1;
        seq_err = 0; busy_cyc = 0; ex = 0; ey = 0;
        @(negedge CLK);
        RECT_X = v.rx; RECT_Y = v.ry; RECT_W = v.rw; RECT_H = v.rh;
        COLOUR_EN = v.col_en;
        VGA_VS = 1'b0;
        for (int cyc = 1; cyc <= WINDOW; cyc++) begin
            @(negedge CLK);
            if (cyc == 20) VGA_VS = 1'b1;
            // Live inputs change after the latch; only the latched copy may matter.
            if (cyc == 12) begin
                RECT_X = 8'd0; RECT_Y = 7'd0; RECT_W = 8'd160; RECT_H = 7'd120;
            end
            if (v.overlap_at != 0 && cyc == v.overlap_at) VGA_VS = 1'b0;
            if (v.overlap_at != 0 && cyc == v.overlap_at + 20) VGA_VS = 1'b1;
            if (BUSY) busy_cyc++;
            if (FB_WE) begin
                if (first_cyc < 0) begin
                    first_cyc  = cyc;
                    first_addr = int'(FB_ADDR);
                end
                last_cyc = cyc;
                writes++;
                exp_addr = {ey[6:0], ex[7:0]};
                if (FB_ADDR != exp_addr) seq_err++;
                if (ex == 159) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
                if (FB_DATA) begin
                    ones++;
                    if (first_one < 0) first_one = int'(FB_ADDR);
                    last_one = int'(FB_ADDR);
                end
            end
        end
        check($sformatf("f%0d first write cycle", idx), first_cyc, 3);
        check($sformatf("f%0d first write addr", idx), first_addr, 0);
        check($sformatf("f%0d write count", idx), writes, 19200);
        check($sformatf("f%0d last write cycle", idx), last_cyc, 19202);
        check($sformatf("f%0d addr sequence errors", idx), seq_err, 0);
        check($sformatf("f%0d foreground pixels", idx), ones, v.exp_ones);
        check($sformatf("f%0d first fg addr", idx), first_one, v.exp_first);
        check($sformatf("f%0d last fg addr", idx), last_one, v.exp_last);
        check($sformatf("f%0d busy cycles", idx), busy_cyc, 19201);
        check($sformatf("f%0d busy at end", idx), int'(BUSY), 0);
        check($sformatf("f%0d frame count", idx), int'(FRAME_COUNT), v.exp_frames);
        check($sformatf("f%0d colours", idx), int'(CONFIG_COLOURS), v.exp_colours);
    endtask

    initial begin
        int we_seen, writes, first_cyc, first_addr;
        logic hit;

        // Basic rectangle, colour updates on: counter 0->1, no colour change yet.
        vecs[0] = '{rx: 8'd10, ry: 7'd20, rw: 8'd4, rh: 7'd3, col_en: 1'b1, overlap_at: 0,
                    exp_ones: 12, exp_first: 20 * 256 + 10, exp_last: 22 * 256 + 13,
                    exp_colours: 'hFF00, exp_frames: 1};
        // Clipped at bottom-right, second VS edge mid-sweep, colour updates off.
        vecs[1] = '{rx: 8'd158, ry: 7'd118, rw: 8'd10, rh: 7'd10, col_en: 1'b0,
                    overlap_at: 5000, exp_ones: 4, exp_first: 118 * 256 + 158,
                    exp_last: 119 * 256 + 159, exp_colours: 'hFF00, exp_frames: 2};
        // Zero width; counter wraps so foreground 0xFF + 0x25 = 0x24.
        vecs[2] = '{rx: 8'd5, ry: 7'd5, rw: 8'd0, rh: 7'd5, col_en: 1'b1, overlap_at: 0,
                    exp_ones: 0, exp_first: -1, exp_last: -1,
                    exp_colours: 'h2400, exp_frames: 3};

        VGA_VS = 1'b1; COLOUR_EN = 1'b0;
        RECT_X = '0; RECT_Y = '0; RECT_W = '0; RECT_H = '0;
        RESET_N = 1'b1;
        #2 RESET_N = 1'b0;

        we_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            VGA_VS = ~VGA_VS;
            if (FB_WE) we_seen++;
        end
        VGA_VS = 1'b1;
        check("reset FB_WE never high", we_seen, 0);
        check("reset FB_WE", int'(FB_WE), 0);
        check("reset FB_ADDR", int'(FB_ADDR), 0);
        check("reset FB_DATA", int'(FB_DATA), 0);
        check("reset CONFIG_COLOURS", int'(CONFIG_COLOURS), 'hFF00);
        check("reset BUSY", int'(BUSY), 0);
        check("reset FRAME_COUNT", int'(FRAME_COUNT), 0);

        @(negedge CLK);
        RESET_N = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (FB_WE || BUSY) we_seen++;
        end
        check("idle after release", we_seen, 0);

        for (int i = 0; i < 3; i++) run_frame(i, vecs[i]);

        // Reset at write 7000 must kill the sweep at once.
        @(negedge CLK);
        RECT_X = 8'd10; RECT_Y = 7'd20; RECT_W = 8'd4; RECT_H = 7'd3;
        VGA_VS = 1'b0;
        writes = 0;
        hit = 1'b0;
        for (int cyc = 1; cyc <= 8000 && !hit; cyc++) begin
            @(negedge CLK);
            if (cyc == 20) VGA_VS = 1'b1;
            if (FB_WE) writes++;
            if (writes == 7000) hit = 1'b1;
        end
        check("mid reached write 7000", int'(hit), 1);
        RESET_N = 1'b0;
        #1;
        check("mid reset FB_WE", int'(FB_WE), 0);
        check("mid reset FB_ADDR", int'(FB_ADDR), 0);
        check("mid reset BUSY", int'(BUSY), 0);
        check("mid reset CONFIG_COLOURS", int'(CONFIG_COLOURS), 'hFF00);
        check("mid reset FRAME_COUNT", int'(FRAME_COUNT), 0);

        we_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (FB_WE) we_seen++;
        end
        RESET_N = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (FB_WE) we_seen++;
        end
        check("no writes until next VS edge", we_seen, 0);

        VGA_VS = 1'b0;
        first_cyc = -1;
        first_addr = -1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (cyc == 5) VGA_VS = 1'b1;
            if (FB_WE && first_cyc < 0) begin
                first_cyc  = cyc;
                first_addr = int'(FB_ADDR);
            end
        end
        check("restart first write cycle", first_cyc, 3);
        check("restart first write addr", first_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_painter.md
# vga_frame_painter

Upstream stage of the VGA signal generator: once per video frame it repaints the 160×120 one-bit frame buffer through the buffer's write port, drawing a filled rectangle on a cleared background. It also drives the 16-bit foreground/background colour word that the signal generator consumes. Repaint starts on the vertical-sync falling edge, so the full sweep completes inside vertical blanking.

## Interface
Parameters:
- FB_W, 160: pixel columns swept (x = 0..FB_W-1)
- FB_H, 120: pixel rows swept (y = 0..FB_H-1)
- COLOUR_PERIOD, 60: frames between colour updates (≥1)
- COLOUR_STEP, 8'h25: amount added to the foreground colour per update

Ports:
- CLK  in  1  system clock; same clock as the signal generator
- RESET_N  in  1  reset, asynchronous, active-low
- VGA_VS  in  1  vertical sync from the signal generator (low = sync pulse)
- RECT_X  in  8  rectangle left column
- RECT_Y  in  7  rectangle top row
- RECT_W  in  8  rectangle width in pixels (0 = no rectangle)
- RECT_H  in  7  rectangle height in pixels (0 = no rectangle)
- COLOUR_EN  in  1  enables periodic colour updates
- FB_WE  out  1  frame-buffer write enable
- FB_ADDR  out  15  write address {y[6:0], x[7:0]}
- FB_DATA  out  1  pixel written (1 = foreground)
- CONFIG_COLOURS  out  16  [15:8] foreground, [7:0] background
- BUSY  out  1  sweep in progress
- FRAME_COUNT  out  16  completed repaints, wraps at 0xFFFF→0

## Operation
- VGA_VS passes through a 2-flop synchroniser. A falling edge is detected on the synchronised signal (previous 1, current 0).
- FSM states: IDLE, SWEEP, UPDATE.
- IDLE:
  - On a detected edge, latch RECT_X/Y/W/H, clear x and y to 0, and go to SWEEP.
  - RECT inputs may change at any time; only the latched copy is used.
- SWEEP:
  - One write per cycle: FB_WE=1, FB_ADDR={y,x}.
  - FB_DATA = (x ≥ RX) && (x < RX+RW) && (y ≥ RY) && (y < RY+RH).
  - Sums are computed 1 bit wider (9-bit x, 8-bit y), so a rectangle running past the screen edge is clipped, never wrapped.
  - x increments each cycle. At x=FB_W-1, x goes to 0 and y increments.
  - At (FB_W-1, FB_H-1), go to UPDATE after that write. Total FB_W·FB_H = 19200 writes.
- UPDATE (one cycle):
  - FB_WE=0; FRAME_COUNT += 1.
  - If COLOUR_EN, a frame counter counts up to COLOUR_PERIOD-1. At its wrap, foreground += COLOUR_STEP (mod 256); background is unchanged.
  - Return to IDLE.
- A VS edge detected while in SWEEP or UPDATE is ignored: no restart, no queueing, no count.
- FB_WE is 0 in every state except SWEEP.

## Timing
- Reset values: FB_WE 0, FB_ADDR 0, FB_DATA 0, CONFIG_COLOURS 16'hFF00, BUSY 0, FRAME_COUNT 0, FSM IDLE, synchroniser flops 1.
- Reset mid-sweep: all outputs return to their reset values asynchronously. No partial write completes after RESET_N falls. After release, painting waits for the next VS falling edge.
- Latency:
  - VGA_VS falls at cycle 0 → edge detected at cycle 2 → first write (addr 0) registered at cycle 3.
  - Last write at cycle 3+19199; UPDATE at cycle 19203; BUSY drops at cycle 19204.
- BUSY is 1 throughout SWEEP and UPDATE.
- All outputs are registered. FB_WE, FB_ADDR and FB_DATA change together.
- Vertical blanking is about 41 lines × 800 × 4 CLK ≈ 131k cycles, far above the 19.2k-cycle sweep.

## Structure
- Shared package/header holds FB_W, FB_H, FB_ADDR_W=15, X_W=8, Y_W=7, the colour reset value 16'hFF00, and the FSM state encodings.
- One sub-module, vs_edge_sync: 2-flop synchroniser plus falling-edge pulse, with asynchronous active-low reset (flops preset to 1).
- Counters are local to this module. Generic_counter is not reused because its reset polarity differs.

## Test plan
- Reset: hold RESET_N low, toggle VGA_VS → all outputs at reset values; FB_WE never asserts.
- Basic rectangle: RECT=(10,20,4,3), drop VGA_VS →
  - exactly 19200 writes in consecutive cycles, first at addr 0 three cycles after the edge;
  - exactly 12 with FB_DATA=1, at {y,x} for y∈20..22, x∈10..13;
  - BUSY high 19201 cycles; FRAME_COUNT=1.
- Clipping: RECT=(158,118,10,10) → only (158..159, 118..119) are 1, i.e. 4 ones. RECT_W=0 → zero ones.
- Overlap: second VS falling edge at cycle 5000 of a sweep → ignored; one sweep only; FRAME_COUNT increments by 1.
- Colours: COLOUR_PERIOD=2, COLOUR_EN=1, three frames → CONFIG_COLOURS goes 16'hFF00 → 16'hFF00 → 16'h2400 → 16'h2400. With COLOUR_EN=0 it stays unchanged.
- Reset mid-sweep: assert RESET_N low at write 7000 → FB_WE=0 immediately. After release, no writes until the next VS edge, which starts again at addr 0.
